// File: rtl/comm_sys_prbs_polytx_pkg.sv
// rtl/comm_sys_prbs_polytx_pkg.sv - shared constants, types and helpers for the PRBS polyphase TX
package comm_sys_prbs_polytx_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS = 2'b00,
    MODE_DC   = 2'b01,
    MODE_ALT  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int PRBS_LEN    = 9;
  localparam int PRBS_TAP_HI = 8;
  localparam int PRBS_TAP_LO = 4;

  // Raised-cosine set, 4 phases x 6 taps, Q1.7, address = phase*6 + tap (address 0 at LSB)
  localparam logic [191:0] DEFAULT_COEFF_INIT =
    192'h01F92271F103_02F14D4DF102_03F17122F901_00007F000000;

  localparam logic [17:0] DEFAULT_SEEDS = {9'h1FE, 9'h1AA};

  function automatic logic [PRBS_LEN-1:0] prbs9_next(input logic [PRBS_LEN-1:0] s);
    return {s[PRBS_LEN-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

  function automatic int acc_width(input int nb_coeffs, input int n_taps);
    return nb_coeffs + $clog2(n_taps) + 1;
  endfunction

endpackage

// File: rtl/comm_sys_prbs_polytx_polyphase_fir_ch.sv
// rtl/comm_sys_prbs_polytx_polyphase_fir_ch.sv - one channel: symbol shift register, +/-coef sum, truncate and saturate
module polyphase_fir_ch
  import comm_sys_prbs_polytx_pkg::*;
#(
  parameter int N_TAPS     = 6,
  parameter int NB_COEFFS  = 8,
  parameter int NBF_COEFFS = 7,
  parameter int NB_OUTPUT  = 8,
  parameter int NBF_OUTPUT = 7
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          shift,
  input  logic                          bit_in,
  input  logic [N_TAPS*NB_COEFFS-1:0]   coefs,
  output logic [NB_OUTPUT-1:0]          sample,
  output logic                          sat
);

  localparam int ACC_W = acc_width(NB_COEFFS, N_TAPS);
  localparam int DROP  = NBF_COEFFS - NBF_OUTPUT;
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (NB_OUTPUT - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  // Bit 0 maps to +1, bit 1 to -1; index 0 holds the newest symbol
  logic [N_TAPS-1:0] shreg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (shift) begin
      shreg <= {shreg[N_TAPS-2:0], bit_in};
    end
  end

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] scaled;

  always_comb begin
    acc    = '0;
    term   = '0;
    sample = '0;
    sat    = 1'b0;
    for (int k = 0; k < N_TAPS; k++) begin
      term = ACC_W'($signed(coefs[k*NB_COEFFS +: NB_COEFFS]));
      acc  = shreg[k] ? acc - term : acc + term;
    end
    scaled = acc >>> DROP;
    if (scaled > OUT_MAX) begin
      sample = OUT_MAX[NB_OUTPUT-1:0];
      sat    = 1'b1;
    end else if (scaled < OUT_MIN) begin
      sample = OUT_MIN[NB_OUTPUT-1:0];
      sat    = 1'b1;
    end else begin
      sample = scaled[NB_OUTPUT-1:0];
    end
  end

endmodule

// File: rtl/comm_sys_prbs_polytx.sv
// rtl/comm_sys_prbs_polytx.sv - multi-channel PRBS9 source with shared polyphase raised-cosine interpolator
module comm_sys_prbs_polytx
  import comm_sys_prbs_polytx_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int N_OS       = 4,
  parameter int N_TAPS     = 6,
  parameter int NB_COEFFS  = 8,
  parameter int NBF_COEFFS = 7,
  parameter int NB_OUTPUT  = 8,
  parameter int NBF_OUTPUT = 7,
  parameter logic [N_OS*N_TAPS*NB_COEFFS-1:0] COEFF_INIT = DEFAULT_COEFF_INIT,
  parameter logic [N_CH*PRBS_LEN-1:0]          SEEDS      = DEFAULT_SEEDS
) (
  input  logic                              clock,
  input  logic                              i_reset_n,
  input  logic                              i_enable,
  input  logic [1:0]                        i_mode,
  input  logic                              i_coef_we,
  input  logic [$clog2(N_OS*N_TAPS)-1:0]    i_coef_addr,
  input  logic [NB_COEFFS-1:0]              i_coef_data,
  output logic [N_CH*NB_OUTPUT-1:0]         o_sample,
  output logic                              o_valid,
  output logic [$clog2(N_OS)-1:0]           o_phase,
  output logic [N_CH-1:0]                   o_sat
);

  localparam int N_COEF  = N_OS * N_TAPS;
  localparam int PW      = $clog2(N_OS);
  localparam int SLICE_W = N_TAPS * NB_COEFFS;

  logic [PW-1:0]               phase;
  logic [N_COEF*NB_COEFFS-1:0] bank;
  logic [PRBS_LEN-1:0]         lfsr [N_CH];
  logic                        toggle;
  logic [N_CH-1:0]             sym_bit;
  logic [SLICE_W-1:0]          coef_slice;
  logic [N_CH*NB_OUTPUT-1:0]   ch_sample;
  logic [N_CH-1:0]             ch_sat;
  logic                        tick;
  mode_e                       mode;

  assign tick       = i_enable && (phase == PW'(N_OS - 1));
  assign mode       = mode_e'(i_mode);
  assign coef_slice = bank[phase*SLICE_W +: SLICE_W];

  // Writes land regardless of i_enable; the filter sees them from the next cycle on
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bank <= COEFF_INIT;
    end else if (i_coef_we && (int'(i_coef_addr) < N_COEF)) begin
      bank[i_coef_addr*NB_COEFFS +: NB_COEFFS] <= i_coef_data;
    end
  end

  // LFSRs and toggle advance on every tick in every mode so PRBS phase survives mode changes
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      toggle <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        lfsr[c] <= SEEDS[c*PRBS_LEN +: PRBS_LEN];
      end
    end else if (tick) begin
      toggle <= ~toggle;
      for (int c = 0; c < N_CH; c++) begin
        lfsr[c] <= prbs9_next(lfsr[c]);
      end
    end
  end

  always_comb begin
    sym_bit = '0;
    for (int c = 0; c < N_CH; c++) begin
      case (mode)
        MODE_DC:  sym_bit[c] = 1'b0;
        MODE_ALT: sym_bit[c] = toggle;
        default:  sym_bit[c] = lfsr[c][PRBS_TAP_HI];
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    polyphase_fir_ch #(
      .N_TAPS     (N_TAPS),
      .NB_COEFFS  (NB_COEFFS),
      .NBF_COEFFS (NBF_COEFFS),
      .NB_OUTPUT  (NB_OUTPUT),
      .NBF_OUTPUT (NBF_OUTPUT)
    ) u_fir (
      .clock   (clock),
      .reset_n (i_reset_n),
      .shift   (tick),
      .bit_in  (sym_bit[c]),
      .coefs   (coef_slice),
      .sample  (ch_sample[c*NB_OUTPUT +: NB_OUTPUT]),
      .sat     (ch_sat[c])
    );
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase    <= '0;
      o_sample <= '0;
      o_valid  <= 1'b0;
      o_phase  <= '0;
      o_sat    <= '0;
    end else if (i_enable) begin
      phase    <= (phase == PW'(N_OS - 1)) ? '0 : phase + 1'b1;
      o_sample <= ch_sample;
      o_sat    <= ch_sat;
      o_phase  <= phase;
      o_valid  <= 1'b1;
    end else begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/comm_sys_prbs_polytx.md
# comm_sys_prbs_polytx

Parametrised multi-channel PRBS9 source plus polyphase raised-cosine transmit filter; successor of the fixed two-channel, 4x, 6-tap PRBS/RC-TX system. Generates N_CH independent PRBS9 bit streams and maps them to ±1 symbols. Interpolates each stream by N_OS through a shared, runtime-writable coefficient bank. Adds test-pattern modes, per-channel saturation flags and an output valid strobe. Sits between the PRBS/BER control logic and the channel/DAC model.

## Interface
- N_CH, 2, number of independent channels (I, Q, ...)
- N_OS, 4, oversampling factor; power of 2, ≥2
- N_TAPS, 6, taps per polyphase branch
- NB_COEFFS, 8, coefficient width, signed
- NBF_COEFFS, 7, coefficient fractional bits
- NB_OUTPUT, 8, output sample width, signed
- NBF_OUTPUT, 7, output fractional bits; ≤ NBF_COEFFS
- COEFF_INIT, default RC set (packed N_OS*N_TAPS*NB_COEFFS, address 0 at LSB), reset coefficient contents
- SEEDS, {9'h1FE, 9'h1AA} (channel 0 at LSB), per-channel PRBS9 seeds; each must be nonzero
- clock  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_enable  in  1  advance datapath; low freezes all state
- i_mode  in  2  00 PRBS, 01 constant +1, 10 alternating +1/−1, 11 reserved (behaves as 00)
- i_coef_we  in  1  coefficient write strobe
- i_coef_addr  in  clog2(N_OS*N_TAPS)  address = phase*N_TAPS + tap
- i_coef_data  in  NB_COEFFS  coefficient value
- o_sample  out  N_CH*NB_OUTPUT  filtered samples, channel 0 at LSB
- o_valid  out  1  o_sample/o_phase updated this cycle
- o_phase  out  clog2(N_OS)  polyphase branch that produced o_sample
- o_sat  out  N_CH  per-channel saturation flag for current o_sample

## Operation
- Phase counter p, 0..N_OS−1: increments on every i_enable cycle and wraps to 0.
- Symbol tick: i_enable high and p == N_OS−1. On a tick, each channel's symbol shift register (N_TAPS entries, index 0 newest) shifts in a new symbol.
- PRBS9 per channel (x^9+x^5+1): emitted bit = lfsr[8]; next = {lfsr[7:0], lfsr[8]^lfsr[4]}. Advances only on a symbol tick, in every mode, so PRBS phase is preserved across mode changes.
- Symbol source by mode:
  - 00: PRBS bit.
  - 01: bit 0.
  - 10: a toggle flop (reset 0) that inverts each tick.
- Mapping: bit 0 → +1, bit 1 → −1.
- Filter, per channel: acc = Σk ±coef[p*N_TAPS+k] using shreg[k]. Negation is done at full width: acc is NB_COEFFS+clog2(N_TAPS)+1 bits, so −(−2^(NB_COEFFS−1)) is exact.
- Output scaling: drop NBF_COEFFS−NBF_OUTPUT LSBs by truncation, then saturate to NB_OUTPUT. o_sat is 1 when clipping occurred.
- Coefficient write: accepted on any cycle, regardless of i_enable. Addresses ≥ N_OS*N_TAPS are ignored. No back-pressure.

## Timing
- Reset values:
  - o_sample 0, o_valid 0, o_phase 0, o_sat 0.
  - p = 0; shift registers all +1 (bit 0); toggle 0.
  - LFSRs = SEEDS; coefficients = COEFF_INIT.
- On an i_enable cycle with counter value p, the next edge registers o_sample, o_sat and o_phase = p, with o_valid = 1. This is a one-cycle registered latency.
- On a non-enable cycle, o_valid is 0 and all other outputs and state hold.
- A symbol shifted in at the p = N_OS−1 edge first contributes to the output registered at the following p = 0 cycle.
- Coefficient write in cycle t is used by the filter computation in cycle t+1 and later. A write to the address being read in cycle t does not affect that cycle's output.
- i_mode is sampled at the symbol tick only; a mid-symbol change takes effect at the next tick.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously), including rewritten coefficients.

## Structure
- Shared package: mode encodings, PRBS9 polynomial/tap constants, default COEFF_INIT and SEEDS constants, width helpers.
- Sub-module `polyphase_fir_ch`: one per channel. It holds the shift register, the ±coef accumulator and the truncate/saturate logic, and consumes the coefficient slice selected by p.
- Top level holds:
  - the phase counter;
  - the coefficient bank;
  - per-channel PRBS9 LFSRs;
  - mode mux;
  - output registers.

## Test plan
- Reset: hold i_reset_n low with i_enable=1 → o_valid=0, o_sample=0, o_sat=0. Release → first o_valid at the first enabled edge, with o_phase=0.
- DC mode 01, default parameters → per channel:
  - phase 0: 8'h7F, o_sat=0;
  - phase 1: sum 129 → 8'h7F, o_sat=1;
  - phase 2: sum 128 → 8'h7F, o_sat=1;
  - phase 3: sum 129 → 8'h7F, o_sat=1.
  - Repeats every 4 cycles.
- PRBS mode, channel 0 seed 9'h1AA → phase-0 samples follow the bit sequence 1,1,0,1,0,1,0,1,0,…, delayed 3 symbols (tap 3 is the peak): +1→8'h7F, −1→8'h81. The sequence period is 511 symbols.
- Coefficient write of addr 3, data 8'h40, in mode 01 → next phase-0 output = 8'h40. Write to addr 24 → no change.
- i_enable low for 5 cycles mid-symbol → o_valid=0 and outputs frozen. On resume, o_phase continues from the next value; no symbol is skipped or duplicated.
- Mode 10 → after N_TAPS symbols, phase-0 output alternates 8'h81/8'h7F per symbol. A mid-symbol switch to mode 00 takes effect only at the next tick.
